// File: rtl/digit_pkg.sv
// digit_pkg: shared sizes, register map and job states
// for the digit-recognition job controller.
package digit_pkg;

  localparam int IMG_BITS = 400;
  localparam int WORD_W   = 16;
  localparam int RESULT_W = 4;
  localparam int N_WORDS  = IMG_BITS / WORD_W;
  localparam int CNT_W    = $clog2(N_WORDS + 1);

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_RESULT  = 3'd2;
  localparam logic [2:0] ADDR_IMAGE   = 3'd3;
  localparam logic [2:0] ADDR_IRQ_ACK = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  localparam int ST_LOADED    = 0;
  localparam int ST_BUSY      = 1;
  localparam int ST_RES_VALID = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_ERR       = 4;
  localparam int ST_CNT_LSB   = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    RUN,
    DONE
  } job_state_t;

endpackage

// File: rtl/image_word_buffer.sv
// image_word_buffer: image register filled one host word at a time,
// with word counter, full flag and overflow detection.
module image_word_buffer
  import digit_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wr_en_i,
  input  logic                clear_i,
  input  logic                hold_i,
  input  logic [WORD_W-1:0]   data_i,
  output logic [IMG_BITS-1:0] image_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                full_o,
  output logic                ovf_o
);

  logic [IMG_BITS-1:0] image_q, image_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full;
  logic                accept;

  assign full   = (count_q == CNT_W'(N_WORDS));
  assign accept = wr_en_i && !hold_i && !full && !clear_i;
  assign ovf_o  = wr_en_i && !clear_i && (hold_i || full);

  // Next image/count: clear only rewinds the counter, bits are kept.
  always_comb begin
    image_d = image_q;
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + CNT_W'(1);
      for (int k = 0; k < N_WORDS; k++) begin
        if (count_q == CNT_W'(k)) begin
          image_d[k*WORD_W +: WORD_W] = data_i;
        end
      end
    end
  end

  // Image and counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      image_q <= '0;
      count_q <= '0;
    end else begin
      image_q <= image_d;
      count_q <= count_d;
    end
  end

  assign image_o = image_q;
  assign count_o = count_q;
  assign full_o  = full;

endmodule

// File: rtl/digit_job_ctrl.sv
// digit_job_ctrl: Avalon-MM sequencer for one digit-recognition job.
// Define IRQ_EN to build the completion interrupt and IRQ_ACK register.
module digit_job_ctrl
  import digit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [WORD_W-1:0]   writedata,
  output logic [WORD_W-1:0]   readdata,
  output logic                eng_start,
  output logic [IMG_BITS-1:0] eng_image,
  input  logic                eng_done,
  input  logic [RESULT_W-1:0] eng_digit,
  output logic                irq
);

  job_state_t          state_q, state_d;
  logic                res_valid_q, res_valid_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                eng_start_q, eng_start_d;
  logic [WORD_W-1:0]   readdata_q, readdata_d;
  logic [WORD_W-1:0]   status_w;

  logic                wr, rd;
  logic                ctrl_wr, img_wr;
  logic                start_req, clear_req;
  logic                can_start, start_go, start_err;
  logic                done_go, last_word;
  logic                running;

  logic [CNT_W-1:0]    img_count;
  logic                img_full;
  logic                img_ovf;

  assign wr        = chipselect && write;
  assign rd        = chipselect && read;
  assign ctrl_wr   = wr && (address == ADDR_CTRL);
  assign img_wr    = wr && (address == ADDR_IMAGE);
  assign clear_req = ctrl_wr && writedata[CTRL_CLEAR];
  assign start_req = ctrl_wr && writedata[CTRL_START] && !clear_req;
  assign running   = (state_q == RUN);
  assign can_start = (state_q == LOADED) || (state_q == DONE);
  assign start_go  = start_req && can_start;
  assign start_err = start_req && !can_start;
  assign done_go   = eng_done && running && !clear_req;
  assign last_word = img_wr && (img_count == CNT_W'(N_WORDS - 1));

  image_word_buffer u_buf (
    .clk_i   (clk),
    .reset_i (reset),
    .wr_en_i (img_wr),
    .clear_i (clear_req),
    .hold_i  (running),
    .data_i  (writedata),
    .image_o (eng_image),
    .count_o (img_count),
    .full_o  (img_full),
    .ovf_o   (img_ovf)
  );

  // Job FSM next state; CLEAR overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear_req) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (last_word) state_d = LOADED;
        end
        LOADED: begin
          if (start_go) state_d = RUN;
        end
        RUN: begin
          if (done_go) state_d = DONE;
        end
        DONE: begin
          if (start_go) state_d = RUN;
          else if (img_wr) state_d = LOADED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status flags, result capture, launch pulse and read mux.
  always_comb begin
    res_valid_d = res_valid_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    result_d    = result_q;
    eng_start_d = start_go;
    readdata_d  = readdata_q;

    status_w                          = '0;
    status_w[ST_LOADED]               = img_full;
    status_w[ST_BUSY]                 = running;
    status_w[ST_RES_VALID]            = res_valid_q;
    status_w[ST_OVF]                  = ovf_q;
    status_w[ST_ERR]                  = err_q;
    status_w[ST_CNT_LSB +: CNT_W]     = img_count;

    if (clear_req) begin
      res_valid_d = 1'b0;
      ovf_d       = 1'b0;
      err_d       = 1'b0;
    end else begin
      if (img_ovf) ovf_d = 1'b1;
      if (start_err) err_d = 1'b1;
      if (img_wr && !running) res_valid_d = 1'b0;
      if (done_go) begin
        res_valid_d = 1'b1;
        result_d    = eng_digit;
      end
    end

    if (rd) begin
      unique case (address)
        ADDR_STATUS: readdata_d = status_w;
        ADDR_RESULT: readdata_d = WORD_W'(result_q);
        default:     readdata_d = '0;
      endcase
    end
  end

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      eng_start_q <= 1'b0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      result_q    <= result_d;
      eng_start_q <= eng_start_d;
      readdata_q  <= readdata_d;
    end
  end

  assign eng_start = eng_start_q;
  assign readdata  = readdata_q;

`ifdef IRQ_EN
  logic irq_q, irq_d;
  logic irq_ack;

  assign irq_ack = wr && (address == ADDR_IRQ_ACK);

  // Completion wins over a same-cycle acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (clear_req) irq_d = 1'b0;
    else if (done_go) irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;
  end

  // Interrupt register.
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_digit_job_ctrl.sv
// tb_digit_job_ctrl: directed table, multi-cycle sequences and a
// randomized run against a behavioural job model (IRQ_EN aware).
module tb_digit_job_ctrl;

  localparam int IMG = 400;
  localparam int WW  = 16;
  localparam int NW  = 25;

`ifdef IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  localparam int OP_W = 0;
  localparam int OP_R = 1;
  localparam int OP_D = 2;
  localparam int OP_N = 3;

  typedef struct {
    int          op;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic        exp_start;
    logic        exp_irq;
  } vec_t;

  logic           clk;
  logic           reset;
  logic           chipselect;
  logic           write;
  logic           read;
  logic [2:0]     address;
  logic [15:0]    writedata;
  logic [15:0]    readdata;
  logic           eng_start;
  logic [IMG-1:0] eng_image;
  logic           eng_done;
  logic [3:0]     eng_digit;
  logic           irq;

  int vectors;
  int miscompares;

  vec_t tbl[$];

  int             m_count;
  logic [IMG-1:0] m_img;
  bit             m_run, m_rv, m_ovf, m_err, m_irq;
  logic [3:0]     m_res;
  logic [15:0]    m_rd;

  digit_job_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .eng_start  (eng_start),
    .eng_image  (eng_image),
    .eng_done   (eng_done),
    .eng_digit  (eng_digit),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int op, logic [2:0] a, logic [15:0] d,
                              logic [15:0] e, logic s, logic q);
    vec_t v;
    v.op = op; v.addr = a; v.data = d;
    v.exp_rd = e; v.exp_start = s; v.exp_irq = q;
    return v;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkimg(string name, logic [IMG-1:0] act,
                        logic [IMG-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 3'd0; writedata = 16'd0;
  endtask

  task automatic do_write(logic [2:0] a, logic [15:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d;
    tick();
    bus_idle();
  endtask

  task automatic do_read(logic [2:0] a, output logic [15:0] d);
    chipselect = 1'b1; write = 1'b0; read = 1'b1; address = a;
    tick();
    d = readdata;
    bus_idle();
  endtask

  task automatic pulse_done(logic [3:0] dg);
    eng_done = 1'b1; eng_digit = dg;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_idle();
    eng_done = 1'b0; eng_digit = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load_img(int base, output logic [IMG-1:0] img);
    img = '0;
    for (int k = 0; k < NW; k++) begin
      do_write(3'd3, 16'(base + k));
      img = img | (IMG'(16'(base + k)) << (k * WW));
    end
  endtask

  initial begin
    logic [15:0]    rv;
    logic [IMG-1:0] exp_img;
    logic [IMG-1:0] scratch;

    vectors = 0;
    miscompares = 0;
    do_reset();

    chk16("reset_readdata", readdata, 16'h0);
    chk1("reset_eng_start", eng_start, 1'b0);
    chk1("reset_irq", irq, 1'b0);
    chkimg("reset_image", eng_image, '0);

    tbl.push_back(mk(OP_R, 3'd1, 16'h0, 16'h0000, 1'b0, 1'b0));
    tbl.push_back(mk(OP_R, 3'd2, 16'h0, 16'h0000, 1'b0, 1'b0));
    for (int k = 0; k < NW; k++)
      tbl.push_back(mk(OP_W, 3'd3, 16'(k + 1), 16'h0, 1'b0, 1'b0));
    tbl.push_back(mk(OP_R, 3'd1, 16'h0, 16'h0321, 1'b0, 1'b0));
    tbl.push_back(mk(OP_W, 3'd3, 16'hDEAD, 16'h0, 1'b0, 1'b0));
    tbl.push_back(mk(OP_R, 3'd1, 16'h0, 16'h0329, 1'b0, 1'b0));
    tbl.push_back(mk(OP_W, 3'd0, 16'h0001, 16'h0, 1'b1, 1'b0));
    tbl.push_back(mk(OP_N, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0));
    tbl.push_back(mk(OP_R, 3'd1, 16'h0, 16'h032B, 1'b0, 1'b0));
    tbl.push_back(mk(OP_W, 3'd3, 16'hBEEF, 16'h0, 1'b0, 1'b0));
    tbl.push_back(mk(OP_D, 3'd0, 16'h0007, 16'h0, 1'b0, 1'b1));
    tbl.push_back(mk(OP_R, 3'd2, 16'h0, 16'h0007, 1'b0, 1'b1));
    tbl.push_back(mk(OP_R, 3'd6, 16'h0, 16'h0000, 1'b0, 1'b1));
    tbl.push_back(mk(OP_R, 3'd1, 16'h0, 16'h032D, 1'b0, 1'b1));
    tbl.push_back(mk(OP_W, 3'd0, 16'h0003, 16'h0, 1'b0, 1'b0));
    tbl.push_back(mk(OP_R, 3'd1, 16'h0, 16'h0000, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_W: do_write(tbl[i].addr, tbl[i].data);
        OP_R: begin
          do_read(tbl[i].addr, rv);
          chk16($sformatf("row%0d_readdata", i), rv, tbl[i].exp_rd);
        end
        OP_D: pulse_done(tbl[i].data[3:0]);
        default: tick();
      endcase
      chk1($sformatf("row%0d_eng_start", i), eng_start, tbl[i].exp_start);
      chk1($sformatf("row%0d_irq", i), irq, tbl[i].exp_irq && HAS_IRQ);
    end

    exp_img = '0;
    for (int k = 0; k < NW; k++)
      exp_img = exp_img | (IMG'(16'(k + 1)) << (k * WW));
    chk16("image_word0", eng_image[15:0], 16'h0001);
    chk16("image_word24", eng_image[399:384], 16'h0019);
    chkimg("image_kept", eng_image, exp_img);

    // START with only 10 words loaded is an error, no launch.
    for (int k = 0; k < 10; k++) begin
      do_write(3'd3, 16'(16'h0100 + k));
      exp_img[k*WW +: WW] = 16'(16'h0100 + k);
    end
    do_write(3'd0, 16'h0001);
    chk1("early_start_no_pulse", eng_start, 1'b0);
    do_read(3'd1, rv);
    chk16("early_start_status", rv, 16'h0150);

    // Finish loading, launch, CLEAR mid-run, late done ignored.
    for (int k = 10; k < NW; k++) begin
      do_write(3'd3, 16'(16'h0100 + k));
      exp_img[k*WW +: WW] = 16'(16'h0100 + k);
    end
    do_read(3'd1, rv);
    chk16("reload_status", rv, 16'h0331);
    do_write(3'd0, 16'h0001);
    chk1("relaunch_pulse", eng_start, 1'b1);
    tick();
    chk1("relaunch_pulse_end", eng_start, 1'b0);
    chkimg("run_image", eng_image, exp_img);
    do_write(3'd0, 16'h0002);
    pulse_done(4'd3);
    do_read(3'd2, rv);
    chk16("clear_run_result", rv, 16'h0007);
    do_read(3'd1, rv);
    chk16("clear_run_status", rv, 16'h0000);
    chk1("clear_run_irq", irq, 1'b0);
    chkimg("clear_keeps_image", eng_image, exp_img);

    // Reset while running.
    load_img(16'h0200, scratch);
    do_write(3'd0, 16'h0001);
    chk1("pre_reset_pulse", eng_start, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk16("run_reset_readdata", readdata, 16'h0);
    chk1("run_reset_eng_start", eng_start, 1'b0);
    chk1("run_reset_irq", irq, 1'b0);
    chkimg("run_reset_image", eng_image, '0);
    pulse_done(4'd9);
    do_read(3'd1, rv);
    chk16("run_reset_status", rv, 16'h0000);
    do_read(3'd2, rv);
    chk16("run_reset_result", rv, 16'h0000);

    // Done and ack in the same cycle, then re-run from DONE.
    load_img(16'h0300, scratch);
    do_write(3'd0, 16'h0001);
    chipselect = 1'b1; write = 1'b1; address = 3'd4; writedata = 16'h0;
    eng_done = 1'b1; eng_digit = 4'd2;
    tick();
    bus_idle();
    eng_done = 1'b0;
    chk1("irq_done_and_ack", irq, HAS_IRQ);
    do_write(3'd4, 16'h0);
    chk1("irq_after_ack", irq, 1'b0);
    do_read(3'd2, rv);
    chk16("ack_result", rv, 16'h0002);
    do_read(3'd1, rv);
    chk16("done_status", rv, 16'h0325);
    do_write(3'd0, 16'h0001);
    chk1("rerun_pulse", eng_start, 1'b1);
    chkimg("rerun_image", eng_image, scratch);
    pulse_done(4'd4);
    do_read(3'd2, rv);
    chk16("rerun_result", rv, 16'h0004);

    // Randomized run against the job model.
    do_reset();
    m_count = 0; m_img = '0; m_run = 0; m_rv = 0; m_ovf = 0;
    m_err = 0; m_irq = 0; m_res = 4'd0; m_rd = 16'h0;

    for (int n = 0; n < 3000; n++) begin
      int   r;
      int   c;
      bit   wr_v, rd_v, clr, stt, imw, ack, full, run0, exp_start;

      bus_idle();
      chipselect = ($urandom_range(0, 9) != 0);
      address = 3'($urandom_range(0, 7));
      writedata = 16'($urandom);
      r = $urandom_range(0, 99);
      if (r < 45) begin
        write = 1'b1; address = 3'd3;
      end else if (r < 55) begin
        write = 1'b1; address = 3'd0;
        c = $urandom_range(0, 19);
        writedata[1:0] = (c == 0) ? 2'b11 : (c == 1) ? 2'b10 :
                         (c == 2) ? 2'b00 : 2'b01;
      end else if (r < 75) begin
        read = 1'b1;
      end else if (r < 80) begin
        write = 1'b1; address = 3'd4;
      end else if (r < 83) begin
        write = 1'b1; address = 3'($urandom_range(5, 7));
      end
      eng_done = ($urandom_range(0, 6) == 0);
      eng_digit = 4'($urandom_range(0, 9));

      wr_v = chipselect && write;
      rd_v = chipselect && read;
      clr  = wr_v && address == 3'd0 && writedata[1];
      stt  = wr_v && address == 3'd0 && writedata[0] && !clr;
      imw  = wr_v && address == 3'd3;
      ack  = wr_v && address == 3'd4 && HAS_IRQ;
      full = (m_count == NW);
      run0 = m_run;

      if (rd_v) begin
        if (address == 3'd1)
          m_rd = {6'd0, 5'(m_count), m_err, m_ovf, m_rv, m_run, full};
        else if (address == 3'd2)
          m_rd = {12'd0, m_res};
        else
          m_rd = 16'h0;
      end

      exp_start = 1'b0;
      if (clr) begin
        m_count = 0; m_run = 0; m_rv = 0;
        m_ovf = 0; m_err = 0; m_irq = 0;
      end else begin
        if (stt) begin
          if (full && !run0) begin
            m_run = 1; exp_start = 1'b1;
          end else begin
            m_err = 1;
          end
        end
        if (imw) begin
          if (run0 || full) begin
            m_ovf = 1;
          end else begin
            m_img = m_img & ~(IMG'(16'hFFFF) << (m_count * WW));
            m_img = m_img | (IMG'(writedata) << (m_count * WW));
            m_count++;
          end
          if (!run0) m_rv = 0;
        end
        if (eng_done && run0) begin
          m_run = 0; m_res = eng_digit; m_rv = 1;
          if (HAS_IRQ) m_irq = 1;
        end else if (ack) begin
          m_irq = 0;
        end
      end

      tick();
      chk1($sformatf("rnd%0d_eng_start", n), eng_start, exp_start);
      chk16($sformatf("rnd%0d_readdata", n), readdata, m_rd);
      chk1($sformatf("rnd%0d_irq", n), irq, m_irq);
      chkimg($sformatf("rnd%0d_image", n), eng_image, m_img);
    end

    bus_idle();
    eng_done = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_job_ctrl.md
Name: digit_job_ctrl

Overview:
Avalon-MM slave controller that sequences one digit-recognition job: collects a 20x20 binary image from 16-bit host writes, launches the inference engine with a start/done handshake, and captures the classified digit for host readback. Sits between the HPS lightweight bridge and the inference engine, and owns the image register that the engine reads. One job is in flight at a time.

Parameters:
IMG_BITS, 400, image size in bits (20x20, 1 bit per pixel)
WORD_W, 16, host data width
RESULT_W, 4, engine result width (digit 0-9)
N_WORDS, IMG_BITS/WORD_W = 25, derived; IMG_BITS must be a multiple of WORD_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  3  register address
writedata  in  WORD_W  host write data
readdata  out  WORD_W  host read data, registered
eng_start  out  1  one-cycle job launch pulse
eng_image  out  IMG_BITS  image to engine; stable from eng_start until eng_done
eng_done  in  1  one-cycle engine completion pulse
eng_digit  in  RESULT_W  engine result, valid with eng_done
irq  out  1  completion interrupt (only with IRQ_EN)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Register map:
  - 0 CTRL (write only): bit0 START, bit1 CLEAR.
  - 1 STATUS (read): bit0 LOADED, bit1 BUSY, bit2 RES_VALID, bit3 OVF (sticky), bit4 ERR (sticky), bits 9:5 word count 0..25.
  - 2 RESULT (read): bits 3:0 digit, other bits 0.
  - 3 IMAGE (write): next image word.
  - 4 IRQ_ACK (write, IRQ_EN only).
  - Unmapped addresses: reads return 0, writes are ignored.
- Reads: readdata is valid the cycle after chipselect && read (1-cycle latency). It holds its value otherwise.
- IMAGE write k (k = 0..24) stores to image[WORD_W*k +: WORD_W]. Word count increments. At count 25, LOADED = 1.
- FSM states:
  - IDLE (count < 25): IMAGE writes accepted.
  - LOADED: START moves to RUN. eng_start pulses exactly one cycle, registered, the cycle after the START write.
  - RUN: BUSY = 1; eng_image frozen.
  - DONE: entered on eng_done in RUN. eng_digit is latched to RESULT and RES_VALID = 1. LOADED, count and the image are kept, so START re-runs the same image.
- Boundary rules:
  - IMAGE write when count == 25 or in RUN: data dropped, OVF set.
  - START in IDLE or RUN: ignored, ERR set.
  - CLEAR in any state: count = 0, LOADED = 0, RES_VALID = 0, OVF = 0, ERR = 0, next state IDLE. Image bits are not zeroed. A CLEAR issued in RUN discards the eventual eng_done.
  - START and CLEAR in the same write: CLEAR wins, no eng_start.
  - eng_done outside RUN: ignored.
  - An IMAGE write in DONE, or any IMAGE write while count < 25, restarts loading: clears RES_VALID, and if count == 25 it is treated as overflow per the rule above.
- Reset values: readdata 0, eng_start 0, irq 0, image 0, count 0, state IDLE, all status bits 0.
- Reset mid-RUN: return to IDLE; a later eng_done is ignored.

Optional Feature:
IRQ_EN
- Defined: irq rises on entry to DONE and stays high until a write to address 4 or CLEAR. An eng_done and an ack in the same cycle leave irq set.
- Undefined: irq port tied 0, address 4 unmapped, no irq register synthesized.

Decomposition:
- Package digit_pkg:
  - IMG_BITS, WORD_W, RESULT_W, N_WORDS.
  - Register address localparams.
  - CTRL/STATUS bit index constants.
  - Enum job_state_t {IDLE, LOADED, RUN, DONE}.
- Sub-module image_word_buffer: IMG_BITS register, word counter, full flag, overflow detection. Inputs: wr_en, clear, hold, data.

Test Plan:
- Reset; write 25 words 16'h0001..16'h0019 to addr 3 -> STATUS = 0x0321 (count 25, LOADED); eng_image[15:0] = 1, [399:384] = 0x19.
- Loaded; write CTRL = 1 -> eng_start high exactly one cycle; BUSY = 1; eng_image unchanged. Drive eng_done with digit 7 -> RESULT reads 7, RES_VALID = 1, BUSY = 0; irq = 1 with IRQ_EN.
- 26th IMAGE write, plus an IMAGE write during RUN -> image unchanged, OVF = 1. CTRL = 1 with 10 words loaded -> no eng_start, ERR = 1.
- Mid-RUN CLEAR, then eng_done with digit 3 -> state IDLE, RES_VALID = 0, RESULT not updated, count 0.
- CTRL write 0x3 while loaded -> no eng_start, state IDLE. Reset asserted in RUN -> all outputs and status 0.
- IRQ_EN: eng_done and an addr 4 write in the same cycle -> irq stays 1; an addr 4 write next cycle -> irq = 0.
